// File: rtl/io_pkg.sv
// Shared types and constants for the IO block.
// Used by the RAM loader and the IO top level.
package io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOW,
        HIGH,
        DONE
    } loader_state_t;

    localparam int IO_IN_WIDTH   = 32;
    localparam int IO_DATA_WIDTH = 64;
    localparam int IO_ADDR_WIDTH = 13;
    localparam int IO_DEPTH      = 100;
    localparam int HDR_COUNT_MSB = 15;

endpackage

// File: rtl/io_ram_loader.sv
// Write-side feeder for the IO dual-read RAM.
// Parses a count header, then packs 32-bit halves into 64-bit RAM writes.
module io_ram_loader
    import io_pkg::*;
#(
    parameter int ADDRESS_WIDTH = IO_ADDR_WIDTH,
    parameter int DATA_WIDTH    = IO_DATA_WIDTH,
    parameter int IN_WIDTH      = IO_IN_WIDTH,
    parameter int DEPTH         = IO_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic                     in_valid,
    input  logic [IN_WIDTH-1:0]      in_data,
    output logic                     in_ready,
    output logic                     WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] address_WR,
    output logic [DATA_WIDTH-1:0]    dataIn,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   words_written
);

    loader_state_t state;

    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [HDR_COUNT_MSB:0]   cnt_q;
    logic [IN_WIDTH-1:0]      low_q;

    logic                     xfer;
    logic [HDR_COUNT_MSB:0]   hdr_n;
    logic [16:0]              hdr_end;
    logic                     hdr_bad;
    logic [16:0]              ww_inc;
    logic                     last_word;

    assign in_ready = (state == HEADER) || (state == LOW) || (state == HIGH);
    assign xfer     = in_valid & in_ready;
    assign hdr_n    = in_data[HDR_COUNT_MSB:0];

    // Bounds check done wide enough that base + N cannot wrap.
    assign hdr_end  = 17'(base_q) + 17'(hdr_n);
    assign hdr_bad  = hdr_end > 17'(DEPTH);

    assign ww_inc    = 17'(words_written) + 17'd1;
    assign last_word = ww_inc == 17'(cnt_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            low_q         <= '0;
            WR_Enable     <= 1'b0;
            address_WR    <= '0;
            dataIn        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            WR_Enable <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        words_written <= '0;
                        busy          <= 1'b1;
                        state         <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (hdr_n == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt_q <= hdr_n;
                            state <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (xfer) begin
                        low_q <= in_data;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (xfer) begin
                        dataIn        <= {in_data, low_q};
                        address_WR    <= base_q
                                       + words_written[ADDRESS_WIDTH-1:0];
                        WR_Enable     <= 1'b1;
                        words_written <= words_written + 1'b1;
                        if (last_word) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= LOW;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_ram_loader.sv
// Self-checking bench for io_ram_loader.
// Random data and valid patterns, checked against a write-list model.
module tb_io_ram_loader;

    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int IW    = 32;
    localparam int DEPTH = 100;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_ready;
    logic          WR_Enable;
    logic [AW-1:0] address_WR;
    logic [DW-1:0] dataIn;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_written;

    int n_assert = 0;
    int n_fail   = 0;
    bit toggle   = 1'b0;
    logic prev_we = 1'b0;
    logic [AW+DW-1:0] wr_q[$];

    io_ram_loader #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .IN_WIDTH     (IW),
        .DEPTH        (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .base_addr    (base_addr),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .WR_Enable    (WR_Enable),
        .address_WR   (address_WR),
        .dataIn       (dataIn),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: logs every RAM write and checks spacing and bounds.
    always @(negedge CLK) begin
        if (WR_Enable) begin
            wr_q.push_back({address_WR, dataIn});
            chk("wr_b2b", 96'(prev_we), 96'(0));
            chk("wr_bound", 96'(address_WR < AW'(DEPTH)), 96'(1));
        end
        prev_we = WR_Enable;
    end

    // mode 0: valid held high, 1: toggled, 2: random
    task automatic push(input logic [IW-1:0] w, input int mode,
                        input bit want_ready);
        bit sent = 1'b0;
        int tries = 0;
        while (!sent && tries < 64) begin
            @(negedge CLK);
            start   = 1'b0;
            in_data = w;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = toggle;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            toggle = ~toggle;
            if (want_ready) chk("ready_held", 96'(in_ready), 96'(1));
            sent = in_valid && in_ready;
            tries++;
        end
        if (!sent) chk("push_timeout", 96'(0), 96'(1));
    endtask

    task automatic begin_load(input int base, input int n, input int mode);
        logic [IW-1:0] hdr;
        @(negedge CLK);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = AW'(base);
        hdr       = $urandom();
        hdr[15:0] = 16'(n);
        push(hdr, mode, 1'b0);
    endtask

    task automatic run_load(input int base, input int n, input int mode,
                            input bit poke_start);
        logic [IW-1:0] words[$];
        logic [IW-1:0] w;
        int wr0;
        wr0 = wr_q.size();
        begin_load(base, n, mode);
        if (base + n > DEPTH) begin
            @(negedge CLK);
            in_valid = 1'b0;
            chk("err_pulse", 96'(error), 96'(1));
            chk("err_busy", 96'(busy), 96'(0));
            chk("err_idle", 96'(in_ready), 96'(0));
            @(negedge CLK);
            chk("err_clear", 96'(error), 96'(0));
            #1;
            chk("err_nowrite", 96'(wr_q.size()), 96'(wr0));
            return;
        end
        if (n == 0) begin
            @(negedge CLK);
            in_valid = 1'b0;
            chk("zero_done", 96'(done), 96'(1));
            chk("zero_busy", 96'(busy), 96'(1));
            @(negedge CLK);
            chk("zero_done_clr", 96'(done), 96'(0));
            chk("zero_idle", 96'(busy), 96'(0));
            chk("zero_ww", 96'(words_written), 96'(0));
            #1;
            chk("zero_nowrite", 96'(wr_q.size()), 96'(wr0));
            return;
        end
        if (poke_start) begin
            @(negedge CLK);
            in_valid  = 1'b0;
            start     = 1'b1;
            base_addr = AW'(base ^ 5);
            chk("poke_low", 96'(in_ready), 96'(1));
            chk("poke_ww", 96'(words_written), 96'(0));
        end
        for (int i = 0; i < 2 * n; i++) begin
            w = $urandom();
            words.push_back(w);
            push(w, mode, 1'b1);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        chk("last_done", 96'(done), 96'(1));
        chk("last_we", 96'(WR_Enable), 96'(1));
        chk("last_ww", 96'(words_written), 96'(n));
        @(negedge CLK);
        chk("end_done_clr", 96'(done), 96'(0));
        chk("end_idle", 96'(busy), 96'(0));
        #1;
        chk("wr_count", 96'(wr_q.size()), 96'(wr0 + n));
        for (int i = 0; i < n && wr0 + i < wr_q.size(); i++)
            chk("wr_entry", 96'(wr_q[wr0 + i]),
                96'({AW'(base + i), words[2*i+1], words[2*i]}));
    endtask

    initial begin
        int wr0;
        logic [IW-1:0] w;

        repeat (3) @(negedge CLK);
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_ready", 96'(in_ready), 96'(0));
        chk("rst_outs", 96'({WR_Enable, done, error, address_WR, words_written}),
            96'(0));
        chk("rst_data", 96'(dataIn), 96'(0));
        RST = 1'b0;

        // basic load with fixed data
        wr0 = wr_q.size();
        begin_load(0, 2, 0);
        push(32'h1111_1111, 0, 1'b1);
        push(32'h2222_2222, 0, 1'b1);
        push(32'h3333_3333, 0, 1'b1);
        push(32'h4444_4444, 0, 1'b1);
        @(negedge CLK);
        in_valid = 1'b0;
        chk("basic_done", 96'({done, WR_Enable}), 96'(3));
        chk("basic_ww", 96'(words_written), 96'(2));
        #1;
        chk("basic_cnt", 96'(wr_q.size()), 96'(wr0 + 2));
        if (wr_q.size() >= wr0 + 2) begin
            chk("basic_w0", 96'(wr_q[wr0]), 96'({13'd0, 64'h2222_2222_1111_1111}));
            chk("basic_w1", 96'(wr_q[wr0+1]), 96'({13'd1, 64'h4444_4444_3333_3333}));
        end

        run_load(97, 3, 1, 1'b0);
        run_load(98, 3, 0, 1'b0);
        run_load(40, 0, 0, 1'b0);
        run_load(10, 2, 0, 1'b1);

        // reset after the fifth handshake
        wr0 = wr_q.size();
        begin_load(20, 4, 0);
        for (int i = 0; i < 4; i++) begin
            w = $urandom();
            push(w, 0, 1'b1);
        end
        @(negedge CLK);
        #2;
        in_valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("mid_rst_outs", 96'({WR_Enable, done, error, busy, in_ready}), 96'(0));
        chk("mid_rst_regs", 96'({address_WR, words_written}), 96'(0));
        chk("mid_rst_data", 96'(dataIn), 96'(0));
        repeat (3) @(negedge CLK);
        chk("mid_rst_writes", 96'(wr_q.size()), 96'(wr0 + 2));
        RST = 1'b0;
        run_load(50, 3, 0, 1'b0);

        for (int k = 0; k < 10; k++)
            run_load($urandom_range(0, 99), $urandom_range(0, 6), 2,
                     1'($urandom_range(0, 1)));

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
